// File: rtl/alu_seq_if.sv
// Handshake bundle between register-file read and the sequential ALU.
// The master drives ops and accepts results; the slave is the ALU.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [4:0]       flags;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle ALU with a {Z,C,F,N,L} flag register, bit-serial shifts and a shift-add multiplier.
// One op per valid/ready handshake; results are held until the consumer takes them.
module alu_seq #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SHAMT_W = 4,
  parameter int unsigned MUL_EN  = 1
) (
  input logic      clk,
  input logic      rst_n,
  alu_seq_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  localparam logic [3:0] OpNop   = 4'h0;
  localparam logic [3:0] OpAnd   = 4'h1;
  localparam logic [3:0] OpOr    = 4'h2;
  localparam logic [3:0] OpXor   = 4'h3;
  localparam logic [3:0] OpNot   = 4'h4;
  localparam logic [3:0] OpAdd   = 4'h5;
  localparam logic [3:0] OpAddu  = 4'h6;
  localparam logic [3:0] OpAddc  = 4'h7;
  localparam logic [3:0] OpAddcu = 4'h8;
  localparam logic [3:0] OpSub   = 4'h9;
  localparam logic [3:0] OpMul   = 4'hA;
  localparam logic [3:0] OpCmp   = 4'hB;
  localparam logic [3:0] OpLsh   = 4'hC;
  localparam logic [3:0] OpRsh   = 4'hD;
  localparam logic [3:0] OpArsh  = 4'hE;
  localparam logic [3:0] OpCmpu  = 4'hF;

  typedef enum logic [1:0] {StIdle, StShift, StMul} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [4:0]         flags_q, flags_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   sh_q, sh_d;
  logic [3:0]         sop_q, sop_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;

  logic               in_ready, accept, is_shift, is_mul, is_nop;
  logic [SHAMT_W-1:0] shamt;
  logic               cin, fz, fc, ff, fn, fl;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   diff, alu_res;
  logic [4:0]         alu_flags;
  logic [WIDTH-1:0]   sh_step;
  logic               sh_cout;
  logic [2*WIDTH-1:0] acc_step;

  assign shamt    = bus.b[SHAMT_W-1:0];
  assign is_shift = (bus.op == OpLsh) || (bus.op == OpRsh) || (bus.op == OpArsh);
  assign is_mul   = (bus.op == OpMul) && (MUL_EN != 0);
  assign is_nop   = (bus.op == OpNop) || (bus.op == OpMul);
  // Held low during reset so nothing is accepted while the flags are being cleared.
  assign in_ready = rst_n && (state_q == StIdle) && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  // Single-cycle ops, including shift by zero.
  always_comb begin
    cin  = ((bus.op == OpAddc) || (bus.op == OpAddcu)) ? flags_q[3] : 1'b0;
    sum  = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, cin};
    diff = bus.a - bus.b;
    alu_res = '0;
    fc = 1'b0;
    ff = 1'b0;
    fn = 1'b0;
    fl = 1'b0;
    case (bus.op)
      OpAnd:          alu_res = bus.a & bus.b;
      OpOr:           alu_res = bus.a | bus.b;
      OpXor:          alu_res = bus.a ^ bus.b;
      OpNot:          alu_res = ~bus.a;
      OpAdd, OpAddc: begin
        alu_res = sum[WIDTH-1:0];
        ff = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (alu_res[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OpAddu, OpAddcu: begin
        alu_res = sum[WIDTH-1:0];
        fc = sum[WIDTH];
      end
      OpSub: begin
        alu_res = diff;
        ff = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OpCmp:          fn = $signed(bus.a) < $signed(bus.b);
      OpCmpu:         fl = bus.a < bus.b;
      OpLsh, OpRsh, OpArsh: alu_res = bus.a;
      default:        alu_res = '0;
    endcase
    fz = ((bus.op == OpCmp) || (bus.op == OpCmpu)) ? (bus.a == bus.b) : (alu_res == '0);
    alu_flags = {fz, fc, ff, fn, fl};
  end

  always_comb begin
    sh_step = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
    sh_cout = sh_q[0];
    case (sop_q)
      OpLsh: begin
        sh_step = {sh_q[WIDTH-2:0], 1'b0};
        sh_cout = sh_q[WIDTH-1];
      end
      OpRsh:   sh_step = {1'b0, sh_q[WIDTH-1:1]};
      default: sh_step = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
    endcase
  end

  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept && is_shift && (shamt != '0)) begin
          state_d = StShift;
        end else if (accept && is_mul) begin
          state_d = StMul;
        end
      end
      StShift: if (cnt_q == CntW'(1)) state_d = StIdle;
      StMul:   if (cnt_q == CntW'(1)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath and result/flag commit; the last iteration commits its own step result.
  always_comb begin
    result_d    = result_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    sh_d        = sh_q;
    sop_d       = sop_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (is_shift && (shamt != '0)) begin
            sh_d  = bus.a;
            sop_d = bus.op;
            cnt_d = CntW'(shamt);
          end else if (is_mul) begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, bus.a};
            mplier_d = bus.b;
            cnt_d    = CntW'(WIDTH);
          end else if (!is_nop) begin
            result_d    = alu_res;
            flags_d     = alu_flags;
            out_valid_d = 1'b1;
          end
        end
      end
      StShift: begin
        sh_d  = sh_step;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          result_d    = sh_step;
          flags_d     = {sh_step == '0, sh_cout, 3'b000};
          out_valid_d = 1'b1;
        end
      end
      StMul: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          result_d    = acc_step[WIDTH-1:0];
          flags_d     = {acc_step[WIDTH-1:0] == '0, acc_step[2*WIDTH-1:WIDTH] != '0, 3'b000};
          out_valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
      sh_q        <= '0;
      sop_q       <= OpNop;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
    end else begin
      result_q    <= result_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
      sh_q        <= sh_d;
      sop_q       <= sop_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed and random checks of alu_seq against an arithmetic reference model.
module tb_alu_seq;
  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W), .SHAMT_W(4), .MUL_EN(1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [4:0]  mflags = 5'b0;
  logic [15:0] got_res;
  logic [4:0]  got_flg;
  int          got_lat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: flags are {Z,C,F,N,L}; lat counts cycles from accept to out_valid.
  function automatic void model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                input logic cf, output logic [15:0] res, output logic [4:0] fl,
                                output int lat, output bit has);
    int sa, sb, sr, n;
    longint p;
    logic z, c, f, ng, l;
    sa = int'($signed(a));
    sb = int'($signed(b));
    n = int'(b[3:0]);
    c = 0; f = 0; ng = 0; l = 0; res = 0; lat = 1; has = 1;
    case (op)
      4'h0: has = 0;
      4'h1: res = a & b;
      4'h2: res = a | b;
      4'h3: res = a ^ b;
      4'h4: res = ~a;
      4'h5, 4'h7: begin
        sr = sa + sb + ((op == 4'h7) ? int'(cf) : 0);
        res = 16'(sr);
        f = (sr > 32767) || (sr < -32768);
      end
      4'h6, 4'h8: begin
        p = longint'(a) + longint'(b) + ((op == 4'h8) ? longint'(cf) : 64'd0);
        res = 16'(p);
        c = p > 65535;
      end
      4'h9: begin
        sr = sa - sb;
        res = 16'(sr);
        f = (sr > 32767) || (sr < -32768);
      end
      4'hA: begin
        p = longint'(a) * longint'(b);
        res = 16'(p);
        c = p > 65535;
        lat = 17;
      end
      4'hB: ng = sa < sb;
      4'hF: l = a < b;
      4'hC: begin
        res = a << n;
        if (n != 0) c = a[16 - n];
        lat = n + 1;
      end
      4'hD: begin
        res = a >> n;
        if (n != 0) c = a[n - 1];
        lat = n + 1;
      end
      default: begin
        res = 16'($signed(a) >>> n);
        if (n != 0) c = a[n - 1];
        lat = n + 1;
      end
    endcase
    z = ((op == 4'hB) || (op == 4'hF)) ? (a == b) : (res == 16'h0);
    fl = {z, c, f, ng, l};
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input string tag);
    logic [15:0] er;
    logic [4:0]  ef;
    int          el, guard;
    bit          has;
    model(op, a, b, mflags[3], er, ef, el, has);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check({tag, ":in_ready"}, 32'(bus.in_ready), 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    if (has) begin
      got_lat = 0;
      do begin
        @(negedge clk);
        got_lat++;
      end while (!bus.out_valid && got_lat < 40);
      got_res = bus.result;
      got_flg = bus.flags;
      check({tag, ":lat"}, 32'(got_lat), 32'(el));
      check({tag, ":result"}, 32'(got_res), 32'(er));
      check({tag, ":flags"}, 32'(got_flg), 32'(ef));
      mflags = ef;
    end else begin
      repeat (3) @(negedge clk);
      check({tag, ":no_valid"}, 32'(bus.out_valid), 0);
      check({tag, ":flags_kept"}, 32'(bus.flags), 32'(mflags));
    end
  endtask

  initial begin
    int seen;
    logic [15:0] er;
    logic [4:0] ef;
    int el;
    bit has;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.op = 4'h0;
    bus.a = '0;
    bus.b = '0;

    #1;
    check("rst:in_ready", 32'(bus.in_ready), 0);
    check("rst:out_valid", 32'(bus.out_valid), 0);
    check("rst:result", 32'(bus.result), 0);
    check("rst:flags", 32'(bus.flags), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Carry chain through the stored C flag
    run_op(4'h6, 16'hFFFF, 16'h0001, "addu");
    check("addu:const", {got_flg, got_res}, {5'b11000, 16'h0000});
    run_op(4'h7, 16'h0001, 16'h0001, "addc");
    check("addc:const", {got_flg, got_res}, {5'b00000, 16'h0003});

    run_op(4'h5, 16'h7FFF, 16'h0001, "add_ovf");
    check("add_ovf:const", {got_flg, got_res}, {5'b00100, 16'h8000});
    run_op(4'h9, 16'h8000, 16'h0001, "sub_ovf");
    check("sub_ovf:const", {got_flg, got_res}, {5'b00100, 16'h7FFF});

    run_op(4'hE, 16'h8001, 16'h0004, "arsh4");
    check("arsh4:const", {got_lat[4:0], got_flg, got_res}, {5'd5, 5'b00000, 16'hF800});
    run_op(4'hC, 16'h1234, 16'h0000, "lsh0");
    check("lsh0:const", {got_lat[4:0], got_res}, {5'd1, 16'h1234});

    run_op(4'hA, 16'h0100, 16'h0100, "mul");
    check("mul:const", {got_lat[4:0], got_flg, got_res}, {5'd17, 5'b11000, 16'h0000});

    run_op(4'h0, 16'h5555, 16'hAAAA, "nop");

    // Reset in the middle of a multiply discards it
    run_op(4'h6, 16'hFFFF, 16'h0001, "pre_rst");
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op = 4'hA;
    bus.a = 16'h1234;
    bus.b = 16'h5678;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midmul:out_valid", 32'(bus.out_valid), 0);
    check("midmul:flags", 32'(bus.flags), 0);
    check("midmul:in_ready", 32'(bus.in_ready), 0);
    mflags = 5'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midmul:idle", 32'(bus.in_ready), 1);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("midmul:no_result", 32'(seen), 0);

    // Backpressure then same-cycle handoff and accept
    model(4'hB, 16'hFFFF, 16'h0001, mflags[3], er, ef, el, has);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.op = 4'hB;
    bus.a = 16'hFFFF;
    bus.b = 16'h0001;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check("cmp:flags_const", 32'(bus.flags), 32'(5'b00010));
    for (int i = 0; i < 3; i++) begin
      check("bp:out_valid", 32'(bus.out_valid), 1);
      check("bp:in_ready", 32'(bus.in_ready), 0);
      check("bp:result", 32'(bus.result), 32'(er));
      check("bp:flags", 32'(bus.flags), 32'(ef));
      @(negedge clk);
    end
    mflags = ef;
    model(4'h1, 16'hF0F0, 16'hFF00, mflags[3], er, ef, el, has);
    bus.in_valid = 1'b1;
    bus.op = 4'h1;
    bus.a = 16'hF0F0;
    bus.b = 16'hFF00;
    bus.out_ready = 1'b1;
    #1 check("handoff:in_ready", 32'(bus.in_ready), 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check("handoff:out_valid", 32'(bus.out_valid), 1);
    check("handoff:result", 32'(bus.result), 32'(er));
    check("handoff:flags", 32'(bus.flags), 32'(ef));
    mflags = ef;

    for (int i = 0; i < 80; i++) begin
      run_op(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
